mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 26 ++
 rtl/mem_responder_if.sv | 21 ++
 rtl/mem_responder_array.sv | 32 +++
 rtl/mem_responder.sv | 121 ++++++++++++
 tb/tb_mem_responder.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// ARM_defs: shared definitions for the memory responder.
// Holds the FSM state encodings, the default geometry/timing constants
// and the address-error check shared by the responder logic.
package ARM_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int          DEF_DEPTH       = 64;
    localparam int          DEF_WAIT_CYCLES = 4;
    localparam logic [31:0] DEF_BASE_ADDR   = 32'd1024;

    // An access is illegal when below the window, beyond the last word,
    // or not word aligned.
    function automatic logic addr_error(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input int unsigned depth);
        logic [31:0] idx;
        idx = (addr - base) >> 2;
        return (addr < base) || (idx >= depth) || (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: MEM-stage request/response bundle.
//   rd_en, wr_en   : read / write request from the pipeline
//   address, wdata : byte address and write data of the access
//   rdata          : registered read data
//   ready          : access complete (pipeline freeze = !ready)
//   err            : one-cycle error pulse
// master = pipeline side, slave = responder side.
interface mem_responder_if;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    modport master (output rd_en, wr_en, address, wdata,
                    input  rdata, ready, err);
    modport slave  (input  rd_en, wr_en, address, wdata,
                    output rdata, ready, err);
endinterface

// File: rtl/mem_responder_array.sv
// mem_array: DEPTH x 32-bit word storage.
//   clk     : clock
//   we_i    : write enable (synchronous write)
//   widx_i  : write word index
//   wdata_i : write data
//   ridx_i  : read word index (combinational read)
//   rdata_o : read data
// The array has no reset so contents survive a responder reset.
module mem_array #(
    parameter int DEPTH = 64,
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] widx_i,
    input  logic [31:0]      wdata_i,
    input  logic [IDX_W-1:0] ridx_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [DEPTH];

    // Synchronous word write.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[widx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/mem_responder.sv
// mem_responder: multi-cycle memory responder for the MEM stage.
//   clk : clock, rising edge
//   rst : synchronous active-low reset
//   bus : mem_responder_if.slave (requests in, rdata/ready/err out)
// A request is latched in IDLE, held for WAIT_CYCLES BUSY cycles, then
// performed on the last BUSY edge; DONE raises ready for one cycle.
module mem_responder
    import ARM_defs::*;
#(
    parameter int          DEPTH       = DEF_DEPTH,
    parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);

    localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        op_rd_q;
    logic        op_wr_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic             req_s;
    logic             addr_err_s;
    logic             access_s;
    logic             mem_we_s;
    logic [IDX_W-1:0] idx_s;
    logic [31:0]      mem_rdata_s;
    logic             ready_s;

    // Decode of the latched access and the combinational ready.
    always_comb begin
        req_s      = bus.rd_en | bus.wr_en;
        addr_err_s = addr_error(addr_q, BASE_ADDR, DEPTH);
        idx_s      = IDX_W'((addr_q - BASE_ADDR) >> 2);
        access_s   = (state_q == ST_BUSY) && (cnt_q == LAST_CNT);
        // Gating with rst keeps an aborted write out of the array.
        mem_we_s   = rst & access_s & op_wr_q & ~addr_err_s;
        case (state_q)
            ST_IDLE: ready_s = ~req_s;
            ST_BUSY: ready_s = 1'b0;
            ST_DONE: ready_s = 1'b1;
            default: ready_s = 1'b0;
        endcase
    end

    mem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_mem_array (
        .clk     (clk),
        .we_i    (mem_we_s),
        .widx_i  (idx_s),
        .wdata_i (wdata_q),
        .ridx_i  (idx_s),
        .rdata_o (mem_rdata_s)
    );

    // Access FSM with latched request, wait counter and registered results.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            op_rd_q <= 1'b0;
            op_wr_q <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    err_q <= 1'b0;
                    if (req_s) begin
                        op_rd_q <= bus.rd_en;
                        op_wr_q <= bus.wr_en;
                        addr_q  <= bus.address;
                        wdata_q <= bus.wdata;
                        cnt_q   <= 4'd0;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    cnt_q <= cnt_q + 4'd1;
                    err_q <= 1'b0;
                    if (cnt_q == LAST_CNT) begin
                        state_q <= ST_DONE;
                        // Simultaneous read+write is itself an error.
                        err_q   <= addr_err_s | (op_rd_q & op_wr_q);
                        // Only a pure read updates rdata.
                        if (op_rd_q && !op_wr_q) begin
                            rdata_q <= addr_err_s ? 32'd0 : mem_rdata_s;
                        end
                    end
                end
                ST_DONE: begin
                    err_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    err_q   <= 1'b0;
                    cnt_q   <= 4'd0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.err   = err_q;
    assign bus.ready = ready_s;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (default parameters:
// DEPTH=64, WAIT_CYCLES=4, BASE_ADDR=1024).
module tb_mem_responder;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_responder_if bus ();

    mem_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one access at a negedge and follow it until ready rises.
    // Reports how many ready=0 cycles were seen, plus err/rdata in DONE.
    task automatic do_access(input logic rd, input logic wr,
                             input logic [31:0] addr, input logic [31:0] wd,
                             output bit done, output int zeros,
                             output logic err_d, output logic [31:0] rd_d,
                             output bit err_early);
        @(negedge clk);
        bus.rd_en   = rd;
        bus.wr_en   = wr;
        bus.address = addr;
        bus.wdata   = wd;
        done = 1'b0; zeros = 0; err_d = 1'b0; rd_d = 32'd0; err_early = 1'b0;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (bus.ready === 1'b1) begin
                done  = 1'b1;
                err_d = bus.err;
                rd_d  = bus.rdata;
                break;
            end
            zeros++;
            if (bus.err !== 1'b0) err_early = 1'b1;
            @(posedge clk);
            #1;
            bus.rd_en   = 1'b0;
            bus.wr_en   = 1'b0;
            bus.address = 32'hFFFF_FFF0;
            bus.wdata   = 32'h0BAD_F00D;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.rd_en = 1'b0; bus.wr_en = 1'b0;
        bus.address = 32'd0; bus.wdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if (bus.ready !== 1'b1 || bus.rdata !== 32'd0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ready=%b rdata=%h err=%b expected ready=1 rdata=0 err=0",
                     bus.ready, bus.rdata, bus.err);
        end
        rst = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (bus.ready !== 1'b1 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: ready=%b err=%b expected ready=1 err=0",
                     bus.ready, bus.err);
        end
    endtask

    task automatic test_write_read();
        bit done, ee; int z; logic e; logic [31:0] r;
        do_access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, done, z, e, r, ee);
        checks++;
        if (!done || z != 5 || ee || e !== 1'b0) begin
            errors++;
            $display("FAIL wr_1024: done=%0d busy=%0d early_err=%0d err=%b expected done=1 busy=5 early_err=0 err=0",
                     done, z, ee, e);
        end
        do_access(1'b1, 1'b0, 32'd1024, 32'd0, done, z, e, r, ee);
        checks++;
        if (!done || z != 5 || ee || e !== 1'b0) begin
            errors++;
            $display("FAIL rd_1024_timing: done=%0d busy=%0d early_err=%0d err=%b expected 1/5/0/0",
                     done, z, ee, e);
        end
        checks++;
        if (r !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rd_1024_data: got %h expected deadbeef", r);
        end
    endtask

    task automatic test_boundary();
        bit done, ee; int z; logic e; logic [31:0] r;
        do_access(1'b0, 1'b1, 32'd1276, 32'h12345678, done, z, e, r, ee);
        do_access(1'b1, 1'b0, 32'd1276, 32'd0, done, z, e, r, ee);
        checks++;
        if (!done || e !== 1'b0 || r !== 32'h12345678) begin
            errors++;
            $display("FAIL rd_1276: done=%0d err=%b rdata=%h expected 1/0/12345678", done, e, r);
        end
        do_access(1'b0, 1'b1, 32'd1280, 32'hCAFEF00D, done, z, e, r, ee);
        checks++;
        if (!done || z != 5 || ee || e !== 1'b1 || r !== 32'h12345678) begin
            errors++;
            $display("FAIL wr_1280_err: done=%0d busy=%0d early_err=%0d err=%b rdata=%h expected 1/5/0/1/12345678",
                     done, z, ee, e, r);
        end
        do_access(1'b0, 1'b1, 32'd1026, 32'hCAFEF00D, done, z, e, r, ee);
        checks++;
        if (!done || e !== 1'b1) begin
            errors++;
            $display("FAIL wr_1026_err: done=%0d err=%b expected 1/1", done, e);
        end
        do_access(1'b1, 1'b0, 32'd1000, 32'd0, done, z, e, r, ee);
        checks++;
        if (!done || e !== 1'b1 || r !== 32'd0) begin
            errors++;
            $display("FAIL rd_1000_err: done=%0d err=%b rdata=%h expected 1/1/00000000", done, e, r);
        end
        do_access(1'b1, 1'b0, 32'd1276, 32'd0, done, z, e, r, ee);
        checks++;
        if (!done || e !== 1'b0 || r !== 32'h12345678) begin
            errors++;
            $display("FAIL rd_1276_again: done=%0d err=%b rdata=%h expected 1/0/12345678", done, e, r);
        end
    endtask

    task automatic test_reset_abort();
        bit done, ee; int z; logic e; logic [31:0] r;
        do_access(1'b0, 1'b1, 32'd1032, 32'h11111111, done, z, e, r, ee);
        @(negedge clk);
        bus.rd_en = 1'b0; bus.wr_en = 1'b1;
        bus.address = 32'd1032; bus.wdata = 32'h22222222;
        @(posedge clk); #1;          // first BUSY cycle begins
        bus.wr_en = 1'b0;
        @(posedge clk); #1;          // second BUSY cycle begins
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (bus.ready !== 1'b1 || bus.rdata !== 32'd0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset_state: ready=%b rdata=%h err=%b expected 1/00000000/0",
                     bus.ready, bus.rdata, bus.err);
        end
        do_access(1'b1, 1'b0, 32'd1032, 32'd0, done, z, e, r, ee);
        checks++;
        if (!done || e !== 1'b0 || r !== 32'h11111111) begin
            errors++;
            $display("FAIL rd_1032_after_abort: done=%0d err=%b rdata=%h expected 1/0/11111111", done, e, r);
        end
    endtask

    task automatic test_rd_wr_both();
        bit done, ee; int z; logic e; logic [31:0] r;
        do_access(1'b1, 1'b0, 32'd1024, 32'd0, done, z, e, r, ee);
        checks++;
        if (r !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL preload_rdata: got %h expected deadbeef", r);
        end
        do_access(1'b1, 1'b1, 32'd1040, 32'hA5A5A5A5, done, z, e, r, ee);
        checks++;
        if (!done || z != 5 || ee || e !== 1'b1 || r !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL both_1040: done=%0d busy=%0d early_err=%0d err=%b rdata=%h expected 1/5/0/1/deadbeef",
                     done, z, ee, e, r);
        end
        do_access(1'b1, 1'b0, 32'd1040, 32'd0, done, z, e, r, ee);
        checks++;
        if (!done || e !== 1'b0 || r !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL rd_1040: done=%0d err=%b rdata=%h expected 1/0/a5a5a5a5", done, e, r);
        end
    endtask

    task automatic test_back_to_back();
        bit done, ee; int z; logic e; logic [31:0] r;
        logic exp_ready;
        @(negedge clk);
        bus.rd_en = 1'b1; bus.wr_en = 1'b0;
        bus.address = 32'd1024; bus.wdata = 32'd0;
        for (int c = 0; c < 18; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            exp_ready = ((c % 6) == 5) ? 1'b1 : 1'b0;
            checks++;
            if (bus.ready !== exp_ready) begin
                errors++;
                $display("FAIL b2b_ready_c%0d: got %b expected %b", c, bus.ready, exp_ready);
            end
            if (exp_ready) begin
                checks++;
                if (bus.rdata !== 32'hDEADBEEF || bus.err !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_done_c%0d: rdata=%h err=%b expected deadbeef/0",
                             c, bus.rdata, bus.err);
                end
            end
            // Disturb the request while the first access is BUSY.
            if (c == 2) begin
                bus.address = 32'd1040; bus.wr_en = 1'b1; bus.wdata = 32'h5A5A5A5A;
            end
            if (c == 5) begin
                bus.address = 32'd1024; bus.wr_en = 1'b0; bus.wdata = 32'd0;
            end
            if (c == 17) bus.rd_en = 1'b0;
        end
        do_access(1'b1, 1'b0, 32'd1040, 32'd0, done, z, e, r, ee);
        checks++;
        if (!done || e !== 1'b0 || r !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL b2b_1040_untouched: done=%0d err=%b rdata=%h expected 1/0/a5a5a5a5", done, e, r);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_write_read();
        test_boundary();
        test_reset_abort();
        test_rd_wr_both();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
